room_temp_model: RTL and testbench

- Closed-loop thermal plant model: consumes the thermostat controller's heating/cooling demands and produces the 5-bit room temperature the controller reads.
- Lets the existing temperature monitor run against a realistic, self-consistent environment instead of a scripted ramp.
- Temperature rises under heating, falls under cooling, drifts toward ambient when idle, and flags a fault when both demands are asserted.

---
 rtl/room_temp_model.sv | 106 ++++++++++
 tb/tb_room_temp_model.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/room_temp_model.sv
// Closed-loop room thermal plant: integrates heating/cooling demand into a
// 5-bit saturating temperature, drifting toward ambient when idle.
module room_temp_model #(
    parameter int INIT_TEMP = 20,
    parameter int AMBIENT   = 12,
    parameter int HEAT_DIV  = 4,
    parameter int COOL_DIV  = 4,
    parameter int DRIFT_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       heating,
    input  logic       cooling,
    input  logic       enable,
    input  logic       load,
    input  logic [4:0] load_temp,
    output logic [4:0] temperature,
    output logic       fault,
    output logic       temp_step,
    output logic       at_max,
    output logic       at_min
);

    typedef enum logic [1:0] {IDLE, HEAT, COOL, FAULT} mode_t;

    localparam logic [4:0] INIT_T = 5'(INIT_TEMP);
    localparam logic [4:0] AMB_T  = 5'(AMBIENT);
    localparam logic [7:0] HEAT_M1  = 8'(HEAT_DIV - 1);
    localparam logic [7:0] COOL_M1  = 8'(COOL_DIV - 1);
    localparam logic [7:0] DRIFT_M1 = 8'(DRIFT_DIV - 1);

    mode_t      mode, mode_nxt;
    logic [7:0] counter;
    logic [7:0] div_m1;
    logic [4:0] temp_nxt;

    // mode register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode <= IDLE;
        else     mode <= mode_nxt;
    end

    // next-state decode straight from the demand inputs
    always_comb begin
        mode_nxt = IDLE;
        case ({heating, cooling})
            2'b11:   mode_nxt = FAULT;
            2'b10:   mode_nxt = HEAT;
            2'b01:   mode_nxt = COOL;
            default: mode_nxt = IDLE;
        endcase
    end

    // mode-dependent outputs: step period and candidate next temperature
    always_comb begin
        div_m1   = DRIFT_M1;
        temp_nxt = temperature;
        case (mode)
            HEAT: begin
                div_m1 = HEAT_M1;
                if (temperature != 5'd31) temp_nxt = temperature + 5'd1;
            end
            COOL: begin
                div_m1 = COOL_M1;
                if (temperature != 5'd0) temp_nxt = temperature - 5'd1;
            end
            IDLE: begin
                if (temperature > AMB_T)      temp_nxt = temperature - 5'd1;
                else if (temperature < AMB_T) temp_nxt = temperature + 5'd1;
            end
            default: temp_nxt = temperature;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            temperature <= INIT_T;
            counter     <= 8'd0;
            temp_step   <= 1'b0;
        end else begin
            temp_step <= 1'b0;
            if (load) begin
                temperature <= load_temp;
                counter     <= 8'd0;
            end else if (mode_nxt != mode) begin
                counter <= 8'd0;
            end else if (enable) begin
                if (mode == FAULT) begin
                    counter <= 8'd0;
                end else if (counter == div_m1) begin
                    counter     <= 8'd0;
                    temperature <= temp_nxt;
                    // saturated or at-ambient steps leave temperature alone: no pulse
                    temp_step   <= (temp_nxt != temperature);
                end else begin
                    counter <= counter + 8'd1;
                end
            end
        end
    end

    assign fault  = (mode == FAULT);
    assign at_max = (temperature == 5'd31);
    assign at_min = (temperature == 5'd0);

endmodule

// File: tb/tb_room_temp_model.sv
// Bench for room_temp_model: vector table plus hand-written multi-cycle runs,
// expectations queued at drive time and checked after each clock edge.
module tb_room_temp_model;

    logic       clk = 1'b0;
    logic       rst;
    logic       heating, cooling, enable, load;
    logic [4:0] load_temp;
    logic [4:0] temperature;
    logic       fault, temp_step, at_max, at_min;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       h, c, en, ld;
        logic [4:0] lt;
        logic [4:0] et;
        logic       ef, es;
    } vec_t;

    typedef struct {
        logic [4:0] et;
        logic       ef, es;
        string      name;
    } exp_t;

    exp_t sb[$];

    room_temp_model dut (
        .clk(clk), .rst(rst), .heating(heating), .cooling(cooling),
        .enable(enable), .load(load), .load_temp(load_temp),
        .temperature(temperature), .fault(fault), .temp_step(temp_step),
        .at_max(at_max), .at_min(at_min)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] et, input logic ef, input logic es);
        logic [8:0] act, req;
        act = {temperature, fault, temp_step, at_max, at_min};
        req = {et, ef, es, (et == 5'd31), (et == 5'd0)};
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got temp=%0d fault=%b step=%b max=%b min=%b, want temp=%0d fault=%b step=%b max=%b min=%b",
                     name, act[8:4], act[3], act[2], act[1], act[0],
                     req[8:4], req[3], req[2], req[1], req[0]);
        end
    endtask

    // drive one cycle of inputs, queue its expectation, clock, then check
    task automatic cyc(input string name, input logic h, c, en, ld, input logic [4:0] lt,
                       input logic [4:0] et, input logic ef, es);
        exp_t e;
        heating = h; cooling = c; enable = en; load = ld; load_temp = lt;
        e.et = et; e.ef = ef; e.es = es; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.name, e.et, e.ef, e.es);
    endtask

    vec_t tbl[$];

    initial begin
        int t;
        // mode switch mid-count, enable freeze, load in FAULT and with enable=0
        tbl.push_back('{0,0,1,1,5'd20, 5'd20,0,0});
        for (int i = 0; i < 3; i++) tbl.push_back('{1,0,1,0,5'd0, 5'd20,0,0});
        for (int i = 0; i < 4; i++) tbl.push_back('{0,1,1,0,5'd0, 5'd20,0,0});
        tbl.push_back('{0,1,1,0,5'd0, 5'd19,0,1});
        tbl.push_back('{0,1,1,0,5'd0, 5'd19,0,0});
        for (int i = 0; i < 10; i++) tbl.push_back('{0,1,0,0,5'd0, 5'd19,0,0});
        tbl.push_back('{0,1,1,0,5'd0, 5'd19,0,0});
        tbl.push_back('{0,1,1,0,5'd0, 5'd19,0,0});
        tbl.push_back('{0,1,1,0,5'd0, 5'd18,0,1});
        tbl.push_back('{1,1,1,1,5'd7, 5'd7,1,0});
        tbl.push_back('{1,1,1,0,5'd0, 5'd7,1,0});
        tbl.push_back('{0,0,0,1,5'd31, 5'd31,0,0});

        heating = 0; cooling = 0; enable = 0; load = 0; load_temp = 0;
        rst = 1'b1;
        #12;
        check("reset", 5'd20, 1'b0, 1'b0);
        rst = 1'b0;
        #1;

        // heating from reset: +1 every 4 edges, saturates at 31
        for (int k = 1; k <= 50; k++) begin
            t = 20 + (k - 1) / 4;
            cyc("heat", 1, 0, 1, 0, 5'd0, 5'(t > 31 ? 31 : t), 0,
                (k > 1 && (k - 1) % 4 == 0 && t <= 31));
        end

        // cooling from 20: -1 every 4 edges, saturates at 0
        cyc("cool_load", 0, 1, 1, 1, 5'd20, 5'd20, 0, 0);
        for (int k = 1; k <= 90; k++) begin
            t = 20 - k / 4;
            cyc("cool", 0, 1, 1, 0, 5'd0, 5'(t < 0 ? 0 : t), 0, (k % 4 == 0 && t >= 0));
        end

        // idle drift down to ambient, then up to ambient
        cyc("drift_load_hi", 0, 0, 1, 1, 5'd20, 5'd20, 0, 0);
        for (int k = 1; k <= 148; k++) begin
            t = 20 - k / 16;
            cyc("drift_down", 0, 0, 1, 0, 5'd0, 5'(t < 12 ? 12 : t), 0, (k % 16 == 0 && t >= 12));
        end
        cyc("drift_load_lo", 0, 0, 1, 1, 5'd5, 5'd5, 0, 0);
        for (int k = 1; k <= 132; k++) begin
            t = 5 + k / 16;
            cyc("drift_up", 0, 0, 1, 0, 5'd0, 5'(t > 12 ? 12 : t), 0, (k % 16 == 0 && t <= 12));
        end

        // fault: both demands freeze temperature; release resumes idle drift
        cyc("fault_load", 0, 0, 1, 1, 5'd20, 5'd20, 0, 0);
        for (int k = 1; k <= 30; k++) cyc("fault_hold", 1, 1, 1, 0, 5'd0, 5'd20, 1, 0);
        for (int k = 1; k <= 17; k++)
            cyc("fault_exit", 0, 0, 1, 0, 5'd0, (k == 17) ? 5'd19 : 5'd20, 0, (k == 17));

        // table vectors
        for (int i = 0; i < tbl.size(); i++)
            cyc($sformatf("tbl%0d", i), tbl[i].h, tbl[i].c, tbl[i].en, tbl[i].ld, tbl[i].lt,
                tbl[i].et, tbl[i].ef, tbl[i].es);

        // async reset mid-heating, right after the step to 27
        cyc("rst_load", 1, 0, 1, 1, 5'd24, 5'd24, 0, 0);
        for (int k = 1; k <= 12; k++)
            cyc("rst_heat", 1, 0, 1, 0, 5'd0, 5'(24 + k / 4), 0, (k % 4 == 0));
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", 5'd20, 1'b0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        for (int k = 1; k <= 9; k++)
            cyc("rst_reentry", 1, 0, 1, 0, 5'd0, 5'(20 + (k - 1) / 4), 0,
                (k > 1 && (k - 1) % 4 == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
